// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: icache, branch predictor and decode-side handshake bundle
interface inst_fetch_queue_if;
  logic        ic_req_valid;
  logic [31:0] ic_pc;
  logic        ic_ready_in;
  logic [31:0] ic_inst;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_pred;
  logic [31:0] deq_target;
  modport master (
    output ic_req_valid, ic_pc, bp_pc, deq_valid, deq_inst, deq_pc, deq_pred, deq_target,
    input  ic_ready_in, ic_inst, bp_taken, deq_ready
  );
  modport slave (
    input  ic_req_valid, ic_pc, bp_pc, deq_valid, deq_inst, deq_pc, deq_pred, deq_target,
    output ic_ready_in, ic_inst, bp_taken, deq_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch, static/dynamic next-PC prediction and circular instruction queue.
// Optional same-cycle fetch-to-decode bypass on an empty queue: define IFQ_BYPASS_EN.
module inst_fetch_queue #(
  parameter int          IQ_WIDTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic [31:0]           clr_pc,
  inst_fetch_queue_if.master    ifq,
  output logic [IQ_WIDTH:0]     iq_count
);
  localparam logic [IQ_WIDTH:0] DEPTH = {1'b1, {IQ_WIDTH{1'b0}}};
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  typedef enum logic [1:0] {FLUSH, RUN, HOLD} state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } entry_t;
  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         pc_q, pc_d;
  logic [IQ_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_WIDTH:0]   count_q, count_d;
  entry_t              mem_q [1<<IQ_WIDTH];
  entry_t              fetch_e, head_e;
  logic [6:0]          opcode;
  logic [31:0]         imm_j, imm_b;
  logic                enq, byp, wr, deq, deq_valid;
  // Decode the fetched word and predict its successor PC
  always_comb begin
    opcode         = ifq.ic_inst[6:0];
    imm_j          = {{11{ifq.ic_inst[31]}}, ifq.ic_inst[31], ifq.ic_inst[19:12], ifq.ic_inst[20], ifq.ic_inst[30:21], 1'b0};
    imm_b          = {{19{ifq.ic_inst[31]}}, ifq.ic_inst[31], ifq.ic_inst[7], ifq.ic_inst[30:25], ifq.ic_inst[11:8], 1'b0};
    fetch_e.inst   = ifq.ic_inst;
    fetch_e.pc     = pc_q;
    fetch_e.pred   = (opcode == OP_JAL) || (opcode == OP_BR && ifq.bp_taken);
    fetch_e.target = !fetch_e.pred ? pc_q + 32'd4 : (opcode == OP_JAL) ? pc_q + imm_j : pc_q + imm_b;
  end
  // Handshakes; a flush or a frozen pipeline suppresses every transfer, so deq_valid drops too
  always_comb begin
    enq       = rdy_in && !clr_in && req_q && ifq.ic_ready_in;
`ifdef IFQ_BYPASS_EN
    byp       = enq && (count_q == '0) && ifq.deq_ready;
`else
    byp       = 1'b0;
`endif
    wr        = enq && !byp;
    deq_valid = rdy_in && !clr_in && ((count_q != '0) || byp);
    deq       = deq_valid && ifq.deq_ready && !byp;
    head_e    = byp ? fetch_e : mem_q[head_q];
  end
  assign ifq.ic_req_valid = req_q;
  assign ifq.ic_pc        = pc_q;
  assign ifq.bp_pc        = pc_q;
  assign ifq.deq_valid    = deq_valid;
  assign ifq.deq_inst     = head_e.inst;
  assign ifq.deq_pc       = head_e.pc;
  assign ifq.deq_pred     = head_e.pred;
  assign ifq.deq_target   = head_e.target;
  assign iq_count         = count_q;
  // Next state: a flush wins over any same-cycle enqueue, dequeue or icache response
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && clr_in) begin
      state_d = FLUSH;
      req_d   = 1'b0;
      pc_d    = clr_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy_in) begin
      pc_d    = enq ? fetch_e.target : pc_q;
      head_d  = head_q + IQ_WIDTH'(deq);
      tail_d  = tail_q + IQ_WIDTH'(wr);
      count_d = count_q + (IQ_WIDTH+1)'(wr) - (IQ_WIDTH+1)'(deq);
      state_d = (state_q == FLUSH) ? RUN : (count_d == DEPTH) ? HOLD : RUN;
      req_d   = (state_d == RUN) && (count_d < DEPTH);
    end
  end
  // Control state with asynchronous reset; the fetch request is a registered FSM output
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= FLUSH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage needs no reset: occupancy alone decides which slots are meaningful
  always_ff @(posedge clk_in) begin
    if (wr) mem_q[tail_q] <= fetch_e;
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed checks against a queue-based reference model
module tb_inst_fetch_queue;
  localparam int          IQW   = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h1000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic           clk_in   = 1'b0;
  logic           rst_n_in = 1'b0;
  logic           rdy_in   = 1'b0;
  logic           clr_in   = 1'b0;
  logic [31:0]    clr_pc   = '0;
  logic [IQW:0]   iq_count;
  inst_fetch_queue_if ifq_i ();
  inst_fetch_queue #(.IQ_WIDTH(IQW), .RESET_PC(RPC)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .clr_in   (clr_in),
    .clr_pc   (clr_pc),
    .ifq      (ifq_i),
    .iq_count (iq_count)
  );
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_flush;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] j_pc, j_tgt;
  logic        j_pred;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = RPC;
    m_flush = 1'b1;
  endtask

  // One clock: drive inputs on the falling edge, compare against the model, advance the model.
  // kind: 0 ALU, 1 JAL, 2 branch, 3 JALR
  task automatic step(input bit rdy, input bit clr, input logic [31:0] cpc, input bit rdyi,
                      input int kind, input logic [31:0] imm, input bit bp, input bit dr);
    logic [31:0] r, inst;
    bit          req_e, byp, dv;
    ent_t        cur, hd;
    @(negedge clk_in);
    r = $urandom;
    case (kind)
      1:       inst = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
      2:       inst = {imm[12], imm[10:5], 5'd2, 5'd3, 3'b000, imm[4:1], imm[11], 7'b1100011};
      3:       inst = {r[31:7], 7'b1100111};
      default: inst = {r[31:7], 7'b0110011};
    endcase
    rdy_in            = rdy;
    clr_in            = clr;
    clr_pc            = cpc;
    ifq_i.ic_ready_in = rdyi;
    ifq_i.ic_inst     = inst;
    ifq_i.bp_taken    = bp;
    ifq_i.deq_ready   = dr;
    #1;
    cur.inst = inst;
    cur.pc   = m_pc;
    cur.pred = (kind == 1) || (kind == 2 && bp);
    cur.tgt  = cur.pred ? m_pc + imm : m_pc + 32'd4;
    req_e    = !m_flush && q.size() < DEPTH;
    byp      = BYP && rdy && !clr && req_e && rdyi && q.size() == 0 && dr;
    dv       = rdy && !clr && (q.size() > 0 || byp);
    chk("ic_req_valid", ifq_i.ic_req_valid, req_e);
    chk("ic_pc", ifq_i.ic_pc, m_pc);
    chk("bp_pc", ifq_i.bp_pc, m_pc);
    chk("iq_count", iq_count, q.size());
    chk("deq_valid", ifq_i.deq_valid, dv);
    if (dv) begin
      hd = byp ? cur : q[0];
      chk("deq_inst", ifq_i.deq_inst, hd.inst);
      chk("deq_pc", ifq_i.deq_pc, hd.pc);
      chk("deq_pred", ifq_i.deq_pred, hd.pred);
      chk("deq_target", ifq_i.deq_target, hd.tgt);
    end
    if (rdy && clr) begin
      q.delete();
      m_pc    = cpc;
      m_flush = 1'b1;
    end else if (rdy) begin
      if (dv && dr && !byp) void'(q.pop_front());
      if (req_e && rdyi) begin
        if (!byp) q.push_back(cur);
        m_pc = cur.tgt;
      end
      m_flush = 1'b0;
    end
  endtask

  task automatic alu(input bit rdyi, input bit dr);
    step(1'b1, 1'b0, 32'h0, rdyi, 0, 32'h0, 1'b0, dr);
  endtask

  task automatic grab_jal();
    if (ifq_i.deq_valid === 1'b1 && ifq_i.deq_pc === 32'h1008) begin
      j_pc   = ifq_i.deq_pc;
      j_pred = ifq_i.deq_pred;
      j_tgt  = ifq_i.deq_target;
    end
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst iq_count", iq_count, 0);
    chk("rst ic_req_valid", ifq_i.ic_req_valid, 0);
    chk("rst deq_valid", ifq_i.deq_valid, 0);
    chk("rst ic_pc", ifq_i.ic_pc, RPC);
    model_reset();
    @(posedge clk_in);
    #2 rst_n_in = 1'b1;
  endtask

  initial begin
    logic [31:0] imm;
    int          kind;
    ifq_i.ic_ready_in = 1'b0;
    ifq_i.ic_inst     = '0;
    ifq_i.bp_taken    = 1'b0;
    ifq_i.deq_ready   = 1'b0;
    j_pc = '0; j_pred = 1'b0; j_tgt = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset iq_count", iq_count, 0);
    chk("reset ic_req_valid", ifq_i.ic_req_valid, 0);
    #1 rst_n_in = 1'b1;
    // straight-line code from RESET_PC, then a JAL +0x20 at 0x1008
    alu(1'b1, 1'b1);
    chk("flush cycle req", ifq_i.ic_req_valid, 0);
    alu(1'b1, 1'b1);
    chk("first ic_pc", ifq_i.ic_pc, 32'h1000);
    chk("first deq_valid", ifq_i.deq_valid, BYP);
    alu(1'b1, 1'b1);
    chk("second ic_pc", ifq_i.ic_pc, 32'h1004);
    chk("steady iq_count", iq_count, BYP ? 0 : 1);
    chk("steady deq_pc", ifq_i.deq_pc, BYP ? 32'h1004 : 32'h1000);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1, 32'h20, 1'b0, 1'b1);
    chk("jal fetch pc", ifq_i.ic_pc, 32'h1008);
    grab_jal();
    alu(1'b1, 1'b1);
    chk("after jal ic_pc", ifq_i.ic_pc, 32'h1028);
    grab_jal();
    chk("jal deq_pc", j_pc, 32'h1008);
    chk("jal deq_pred", j_pred, 1);
    chk("jal deq_target", j_tgt, 32'h1028);
    // BEQ at 0x2000, imm -8, taken then not taken
    step(1'b1, 1'b1, 32'h2000, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    alu(1'b1, 1'b1);
    chk("clr flush req", ifq_i.ic_req_valid, 0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 2, 32'hFFFF_FFF8, 1'b1, 1'b1);
    chk("beq fetch pc", ifq_i.ic_pc, 32'h2000);
    alu(1'b0, 1'b1);
    chk("beq taken pc", ifq_i.ic_pc, 32'h1FF8);
    step(1'b1, 1'b1, 32'h2000, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    alu(1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 2, 32'hFFFF_FFF8, 1'b0, 1'b1);
    alu(1'b0, 1'b1);
    chk("beq not-taken pc", ifq_i.ic_pc, 32'h2004);
    // fill to full with decode stalled, then free one slot
    step(1'b1, 1'b1, 32'h3000, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    alu(1'b0, 1'b0);
    repeat (4) alu(1'b1, 1'b0);
    alu(1'b0, 1'b0);
    chk("full iq_count", iq_count, 4);
    chk("full ic_req_valid", ifq_i.ic_req_valid, 0);
    alu(1'b0, 1'b1);
    chk("full deq_valid", ifq_i.deq_valid, 1);
    alu(1'b0, 1'b0);
    chk("after deq iq_count", iq_count, 3);
    chk("after deq ic_req_valid", ifq_i.ic_req_valid, 1);
    chk("after deq ic_pc", ifq_i.ic_pc, 32'h3010);
    // flush with a same-cycle icache response
    step(1'b1, 1'b1, 32'h4000, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    alu(1'b0, 1'b0);
    chk("clr iq_count", iq_count, 0);
    chk("clr deq_valid", ifq_i.deq_valid, 0);
    chk("clr ic_req_valid", ifq_i.ic_req_valid, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 0, 32'h0, 1'b0, 1'b1);
    chk("redirect req", ifq_i.ic_req_valid, 1);
    chk("redirect ic_pc", ifq_i.ic_pc, 32'h4000);
    alu(1'b0, 1'b0);
    chk("frozen ic_pc", ifq_i.ic_pc, 32'h4000);
    chk("frozen iq_count", iq_count, 0);
    // randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      kind = int'($urandom_range(0, 3));
      imm  = (kind == 1) ? 32'($urandom_range(0, 4095)) * 2 - 32'd4096
                         : 32'($urandom_range(0, 1023)) * 2 - 32'd1024;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 31) == 0, $urandom & 32'h0000_FFFC,
           $urandom_range(0, 1) == 1, kind, imm, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
